// File: rtl/wb_tgt_mem_if.sv
// Wishbone target-side bus bundle for wb_tgt_mem.
// Signal names are the target's port names, so the _i/_o suffixes read from the memory's side.
interface wb_tgt_mem_if #(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1
) ();
    logic                  tgt_cyc_i;
    logic                  tgt_stb_i;
    logic                  tgt_we_i;
    logic                  tgt_lock_i;
    logic [SEL_WIDTH-1:0]  tgt_sel_i;
    logic [ADR_WIDTH-1:0]  tgt_adr_i;
    logic [DAT_WIDTH-1:0]  tgt_dat_i;
    logic [TGA_WIDTH-1:0]  tgt_tga_i;
    logic [TGC_WIDTH-1:0]  tgt_tgc_i;
    logic [TGWD_WIDTH-1:0] tgt_tgd_i;
    logic                  tgt_ack_o;
    logic                  tgt_err_o;
    logic                  tgt_rty_o;
    logic                  tgt_stall_o;
    logic [DAT_WIDTH-1:0]  tgt_dat_o;
    logic [TGRD_WIDTH-1:0] tgt_tgd_o;

    modport slave (
        input  tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_lock_i, tgt_sel_i,
               tgt_adr_i, tgt_dat_i, tgt_tga_i, tgt_tgc_i, tgt_tgd_i,
        output tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o, tgt_tgd_o
    );

    modport master (
        output tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_lock_i, tgt_sel_i,
               tgt_adr_i, tgt_dat_i, tgt_tga_i, tgt_tgc_i, tgt_tgd_i,
        input  tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o, tgt_tgd_o
    );
endinterface

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target memory: byte-writable register file with a fixed-latency
// response pipeline, an outstanding-request limit and cycle-abort handling.
module wb_tgt_mem #(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic          clk_i,
    input  logic          async_rst_i,
    input  logic          sync_rst_i,
    wb_tgt_mem_if.slave   bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [DAT_WIDTH-1:0]  mem_reg [WORDS];
    logic [LATENCY-1:0]    vld_reg;
    logic [LATENCY-1:0]    err_reg;
    logic [DAT_WIDTH-1:0]  dat_reg [LATENCY];
    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;

    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  stall;
    logic                  accept;
    logic                  wr_en;
    logic                  retire;
    logic                  out_vld;
    logic [DAT_WIDTH-1:0]  rd_word;
    logic [DAT_WIDTH-1:0]  wr_word;
    logic [DAT_WIDTH-1:0]  rsp_dat;

    assign idx      = bus.tgt_adr_i[DEPTH_LOG2-1:0];
    assign in_range = (bus.tgt_adr_i[ADR_WIDTH-1:DEPTH_LOG2] == '0);
    assign stall    = (cnt_reg == CNT_W'(MAX_OUT));
    assign accept   = bus.tgt_cyc_i & bus.tgt_stb_i & ~stall;
    assign wr_en    = accept & bus.tgt_we_i & in_range;
    assign rd_word  = mem_reg[idx];
    assign rsp_dat  = (in_range && !bus.tgt_we_i) ? rd_word : '0;

    // Read-modify-write merge: selected lanes take new data, the rest keep the stored word.
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_byte
        assign wr_word[8*gi +: 8] = bus.tgt_sel_i[gi] ? bus.tgt_dat_i[8*gi +: 8]
                                                      : rd_word[8*gi +: 8];
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int i = 0; i < WORDS; i++) mem_reg[i] <= '0;
        end else if (sync_rst_i) begin
            for (int i = 0; i < WORDS; i++) mem_reg[i] <= '0;
        end else if (wr_en) begin
            mem_reg[idx] <= wr_word;
        end
    end

    // Response pipeline; a dropped cycle flushes every in-flight entry.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            vld_reg <= '0;
            err_reg <= '0;
            for (int i = 0; i < LATENCY; i++) dat_reg[i] <= '0;
        end else if (sync_rst_i || !bus.tgt_cyc_i) begin
            vld_reg <= '0;
            err_reg <= '0;
            for (int i = 0; i < LATENCY; i++) dat_reg[i] <= '0;
        end else begin
            vld_reg[0] <= accept;
            err_reg[0] <= ~in_range;
            dat_reg[0] <= rsp_dat;
            for (int i = 1; i < LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                err_reg[i] <= err_reg[i-1];
                dat_reg[i] <= dat_reg[i-1];
            end
        end
    end

    // An entry is released from the count as it moves into the output stage, so the
    // registered stall already knows about the slot freed by the response being presented.
    if (LATENCY == 1) begin : g_ret_direct
        assign retire = accept;
    end else begin : g_ret_stage
        assign retire = vld_reg[LATENCY-2];
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (!bus.tgt_cyc_i) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(accept) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cnt_reg <= '0;
        end else if (sync_rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Responses are suppressed while the initiator has abandoned the cycle.
    assign out_vld         = vld_reg[LATENCY-1] & bus.tgt_cyc_i;
    assign bus.tgt_ack_o   = out_vld & ~err_reg[LATENCY-1];
    assign bus.tgt_err_o   = out_vld & err_reg[LATENCY-1];
    assign bus.tgt_dat_o   = bus.tgt_ack_o ? dat_reg[LATENCY-1] : '0;
    assign bus.tgt_rty_o   = 1'b0;
    assign bus.tgt_stall_o = stall;
    assign bus.tgt_tgd_o   = {TGRD_WIDTH{1'b0}};

    logic [TGA_WIDTH+TGC_WIDTH+TGWD_WIDTH:0] unused_tags;
    assign unused_tags = {bus.tgt_lock_i, bus.tgt_tga_i, bus.tgt_tgc_i, bus.tgt_tgd_i};
endmodule
